rx_frame_fifo: RTL and testbench
================================

// Module: rx_frame_fifo
// PURPOSE
// Downstream stage of the UART receive SIPO. It captures each received frame on the SIPO's
// rx_done pulse, strips and checks the parity bit, and restores UART LSB-first bit order.
// Checked bytes are buffered, tagged with their error flag, in a first-word-fall-through FIFO
// that the host drains over a valid/ready handshake.
// PARAMETERS
// DATA_W      8     payload bits per frame; the SIPO frame width is DATA_W+1
// DEPTH       8     FIFO entries; power of two, >=2
// PARITY_ODD  0     0 = even parity expected, 1 = odd parity expected
// PORTS
// Rx_clk        in   1             receiver clock, same domain as the SIPO
// rst           in   1             asynchronous, active-high reset
// rx_done       in   1             SIPO frame-complete strobe
// rx_frame      in   DATA_W+1      SIPO data_out: [DATA_W] = first serial bit (byte LSB), [0] = parity
// m_data        out  DATA_W        head byte, bit order restored (bit0 = first serial bit)
// m_perr        out  1             parity error flag of the head entry
// m_valid       out  1             FIFO not empty
// m_ready       in   1             consumer accepts the head entry
// overrun       out  1             sticky: a frame was dropped because the FIFO was full
// perr_cnt      out  8             saturating count of parity-error frames written into the FIFO
// clr_status    in   1             synchronous clear of overrun and perr_cnt
// level         out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
// - Reset (async): FIFO empty, rd/wr ptrs=0, m_valid=0, m_data=0, m_perr=0, overrun=0,
//   perr_cnt=0, level=0, rx_done_q=0.
// - Capture: a write request occurs only on a rx_done rising edge (rx_done & ~rx_done_q).
//   rx_done held high for more than 1 cycle yields exactly one write.
// - Byte = bit-reverse of rx_frame[DATA_W:1].
//   perr = (^rx_frame) ^ PARITY_ODD. perr=1 means mismatch.
// - Write: {perr, byte} is stored at wr_ptr on the edge after the request.
//   m_valid rises 1 cycle after the rx_done rising edge when the FIFO was empty.
// - FWFT: m_data and m_perr show the head entry whenever m_valid=1.
//   When m_valid=0 they hold the last value; the bench must not check them then.
// - Pop: occurs when m_valid & m_ready. rd_ptr advances and the next entry appears the next cycle.
// - Push while full and no pop in the same cycle: the frame is dropped and overrun is set to 1.
//   The dropped frame does not count toward perr_cnt.
// - Push while full with a pop in the same cycle: both happen, level is unchanged, no overrun.
// - Push while empty with m_ready=1: no same-cycle bypass. The entry becomes visible next cycle.
// - perr_cnt increments when a perr=1 entry is written and saturates at 8'hFF.
// - clr_status takes priority over a same-cycle set or increment: result overrun=0, perr_cnt=0.
// - Pointers are log2(DEPTH)+1 bits with a wrap bit:
//   full = MSBs differ & LSBs equal; empty = pointers equal; level = wr_ptr - rd_ptr.
// - Reset mid-operation empties the FIFO immediately. Entries in flight are lost and m_valid drops
//   asynchronously.
// STRUCTURE
// - uart_pkg: DATA_W default, FRAME_W = DATA_W+1, function bit_rev(), function
//   parity_err(frame, odd), typedef struct packed {logic perr; logic [DATA_W-1:0] data;} rx_entry_t.
// - Sub-module sync_fifo #(WIDTH, DEPTH): FWFT storage, pointers, full/empty/level, simultaneous
//   push/pop.
// - Top level: edge detect, reorder, parity check, overrun and counter logic.
// TESTING
// 1 Even parity. frame {8'b1000_0000,1'b1} with rx_done 1-cycle pulse -> 1 cycle later
//   m_valid=1, m_data=8'h01, m_perr=0, level=1.
// 2 Parity error. frame {8'h00,1'b1}, PARITY_ODD=0 -> m_perr=1, perr_cnt=1. After 256 such
//   frames, popped as they arrive, perr_cnt stays at 8'hFF.
// 3 Overflow. m_ready=0, 9 frames into DEPTH=8 -> level=8, overrun=1, popped order equals frames
//   1..8, frame 9 absent. clr_status -> overrun=0.
// 4 Full push + pop same cycle. FIFO full, m_ready=1 during rx_done edge -> level stays 8,
//   overrun=0, new byte becomes the tail.
// 5 rx_done held 3 cycles -> exactly one entry written (level=1).
// 6 Async reset asserted mid-burst with level=5 -> m_valid=0, level=0 before the next Rx_clk
//   edge. Traffic after release is normal.

Source files
------------

// File: rtl/rx_frame_fifo_pkg.sv
// Shared UART receive definitions: default payload width, frame layout and
// helpers for restoring LSB-first bit order and checking the parity bit.
package uart_pkg;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = DATA_W + 1;

  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  // The SIPO shifts in LSB first, so the first serial bit lands in the MSB.
  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  function automatic logic parity_err(input logic [FRAME_W-1:0] frame, input logic odd);
    return (^frame) ^ odd;
  endfunction

endpackage

// File: rtl/rx_frame_fifo_sync_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; accepts a push and a
// pop in the same cycle even when full.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_hold;
  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~w_empty;
  // A pop frees the head slot this cycle, so a full FIFO can still take the push.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_hold   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_hold   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

  // While empty, present the last entry handed out rather than a stale slot.
  assign o_rd_data = w_empty ? r_hold : r_mem[r_rd_ptr[AW-1:0]];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/rx_frame_fifo.sv
// UART receive back end: captures SIPO frames on the rx_done rising edge,
// checks parity, restores bit order and buffers bytes for the host.
module rx_frame_fifo
  import uart_pkg::*;
#(
  parameter int   DATA_W     = uart_pkg::DATA_W,
  parameter int   DEPTH      = 8,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic                    Rx_clk,
  input  logic                    rst,
  input  logic                    rx_done,
  input  logic [DATA_W:0]         rx_frame,
  output logic [DATA_W-1:0]       m_data,
  output logic                    m_perr,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    overrun,
  output logic [7:0]              perr_cnt,
  input  logic                    clr_status,
  output logic [$clog2(DEPTH):0]  level
);

  logic            r_rx_done_q;
  logic            r_overrun;
  logic [7:0]      r_perr_cnt;
  logic            w_req;
  logic            w_pop;
  logic            w_drop;
  logic            w_push_ok;
  logic            w_full;
  logic            w_empty;
  logic [DATA_W:0] w_wr_data;
  logic [DATA_W:0] w_rd_data;

  assign w_req     = rx_done & ~r_rx_done_q;
  assign w_pop     = ~w_empty & m_ready;
  assign w_drop    = w_req & w_full & ~w_pop;
  assign w_push_ok = w_req & ~w_drop;

  generate
    if (DATA_W == uart_pkg::DATA_W) begin : g_pkg_fmt
      rx_entry_t w_entry;
      always_comb begin
        w_entry.perr = parity_err(rx_frame, PARITY_ODD);
        w_entry.data = bit_rev(rx_frame[DATA_W:1]);
      end
      assign w_wr_data = w_entry;
    end else begin : g_gen_fmt
      logic [DATA_W-1:0] w_byte;
      always_comb begin
        w_byte = '0;
        for (int i = 0; i < DATA_W; i++) begin
          w_byte[i] = rx_frame[DATA_W-i];
        end
      end
      assign w_wr_data = {(^rx_frame) ^ PARITY_ODD, w_byte};
    end
  endgenerate

  always_ff @(posedge Rx_clk or posedge rst) begin
    if (rst) begin
      r_rx_done_q <= 1'b0;
    end else begin
      r_rx_done_q <= rx_done;
    end
  end

  // Clear wins over a same-cycle set or increment; dropped frames never count.
  always_ff @(posedge Rx_clk or posedge rst) begin
    if (rst) begin
      r_overrun  <= 1'b0;
      r_perr_cnt <= 8'h00;
    end else if (clr_status) begin
      r_overrun  <= 1'b0;
      r_perr_cnt <= 8'h00;
    end else begin
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
      if (w_push_ok && w_wr_data[DATA_W] && (r_perr_cnt != 8'hFF)) begin
        r_perr_cnt <= r_perr_cnt + 8'h01;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (Rx_clk),
    .i_rst     (rst),
    .i_push    (w_push_ok),
    .i_wr_data (w_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (level)
  );

  assign m_valid  = ~w_empty;
  assign m_perr   = w_rd_data[DATA_W];
  assign m_data   = w_rd_data[DATA_W-1:0];
  assign overrun  = r_overrun;
  assign perr_cnt = r_perr_cnt;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Randomized and directed checks of rx_frame_fifo against a queue-based
// model of frame capture, parity checking and FIFO behaviour.
module tb_rx_frame_fifo;

  localparam int   DATA_W     = 8;
  localparam int   DEPTH      = 8;
  localparam logic PARITY_ODD = 1'b0;

  logic              clk;
  logic              rst;
  logic              rx_done;
  logic [DATA_W:0]   rx_frame;
  logic [DATA_W-1:0] m_data;
  logic              m_perr;
  logic              m_valid;
  logic              m_ready;
  logic              overrun;
  logic [7:0]        perr_cnt;
  logic              clr_status;
  logic [3:0]        level;

  rx_frame_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .Rx_clk     (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_frame   (rx_frame),
    .m_data     (m_data),
    .m_perr     (m_perr),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .overrun    (overrun),
    .perr_cnt   (perr_cnt),
    .clr_status (clr_status),
    .level      (level)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state: entries are {perr, byte}
  logic [DATA_W:0] exp_q[$];
  logic            mdl_ovr;
  int              mdl_cnt;
  logic            mdl_prev;
  int              n_cmp;
  int              n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial order is b[0] first; the first serial bit sits at frame[DATA_W].
  function automatic logic [DATA_W:0] make_frame(input logic [DATA_W-1:0] b, input logic bad);
    logic [DATA_W:0] f;
    int ones;
    ones = $countones(b);
    for (int i = 0; i < DATA_W; i++) f[DATA_W-i] = b[i];
    f[0] = ((ones % 2) == 1) ^ PARITY_ODD ^ bad;
    return f;
  endfunction

  function automatic logic [DATA_W:0] make_entry(input logic [DATA_W-1:0] b, input logic bad);
    return {bad, b};
  endfunction

  task automatic compare_all();
    check("m_valid", m_valid, exp_q.size() != 0);
    check("level", level, exp_q.size());
    check("overrun", overrun, mdl_ovr);
    check("perr_cnt", perr_cnt, mdl_cnt);
    if (exp_q.size() != 0) begin
      check("m_data", m_data, exp_q[0][DATA_W-1:0]);
      check("m_perr", m_perr, exp_q[0][DATA_W]);
    end
  endtask

  // driver: one clock of stimulus, check at negedge, model step at posedge
  task automatic cycle(input logic done, input logic [DATA_W-1:0] b, input logic bad,
                       input logic ready, input logic clr);
    logic req, pop, ok;
    rx_done    = done;
    rx_frame   = make_frame(b, bad);
    m_ready    = ready;
    clr_status = clr;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    req = done & ~mdl_prev;
    pop = (exp_q.size() != 0) & ready;
    ok  = req & ((exp_q.size() < DEPTH) | pop);
    if (pop) void'(exp_q.pop_front());
    if (ok) exp_q.push_back(make_entry(b, bad));
    if (clr) begin
      mdl_ovr = 1'b0;
      mdl_cnt = 0;
    end else begin
      if (req & ~ok) mdl_ovr = 1'b1;
      if (ok & bad & (mdl_cnt < 255)) mdl_cnt++;
    end
    mdl_prev = done;
    #1;
  endtask

  task automatic idle(input int n, input logic ready);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, ready, 1'b0);
  endtask

  task automatic send(input logic [DATA_W-1:0] b, input logic bad, input logic ready);
    cycle(1'b1, b, bad, ready, 1'b0);
    cycle(1'b0, b, bad, ready, 1'b0);
  endtask

  task automatic async_reset();
    rst     = 1'b1;
    rx_done = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_level", level, 0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    mdl_ovr  = 1'b0;
    mdl_cnt  = 0;
    mdl_prev = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    mdl_ovr = 1'b0; mdl_cnt = 0; mdl_prev = 1'b0;
    rst = 1'b1; rx_done = 1'b0; rx_frame = '0; m_ready = 1'b0; clr_status = 1'b0;

    @(negedge clk);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", m_data, 8'h00);
    check("reset_m_perr", m_perr, 1'b0);
    check("reset_level", level, 0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_perr_cnt", perr_cnt, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;

    // even parity, single pulse, visible one cycle later
    check("t1_frame", make_frame(8'h01, 1'b0), 9'b1000_0000_1);
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    check("t1_valid", m_valid, 1'b1);
    check("t1_data", m_data, 8'h01);
    check("t1_perr", m_perr, 1'b0);
    check("t1_level", level, 1);
    idle(2, 1'b1);

    // parity errors, counter saturation
    for (int i = 0; i < 256; i++) send(8'h00, 1'b1, 1'b1);
    idle(1, 1'b1);
    check("t2_perr_cnt_sat", perr_cnt, 8'hFF);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

    // overflow with stalled consumer
    for (int i = 0; i < DEPTH + 1; i++) send(8'h10 + 8'(i), 1'(i % 3 == 0), 1'b0);
    check("t3_level", level, DEPTH);
    check("t3_overrun", overrun, 1'b1);
    idle(DEPTH + 1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t3_overrun_clr", overrun, 1'b0);

    // full FIFO, push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) send(8'h40 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0);
    check("t4_level", level, DEPTH);
    check("t4_overrun", overrun, 1'b0);
    idle(DEPTH + 1, 1'b1);

    // held rx_done writes once
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    check("t5_level", level, 1);
    idle(2, 1'b1);

    // async reset mid-burst
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    check("t6_level_pre", level, 5);
    async_reset();
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b1);
    idle(2, 1'b1);

    // random traffic with varying consumer pressure
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 600; i++) begin
        cycle(1'($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) < ph + 1), 1'($urandom_range(0, 99) == 0));
      end
    end
    idle(DEPTH + 2, 1'b1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
